// File: rtl/mpc_types.sv
// Shared crossbar types: upstream request format plus key-order-buffer helpers.
package mpc_types;

  localparam int unsigned AddrW = 32;

  typedef enum logic [1:0] {
    OpLoad  = 2'd0,
    OpStore = 2'd1,
    OpAmo   = 2'd2,
    OpNop   = 2'd3
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [AddrW-1:0] addr;
  } channel_req_t;

  typedef struct packed {
    int unsigned num_ch;
    int unsigned depth;
    int unsigned bank_w;
    int unsigned bank_lsb;
  } kob_cfg_t;

  localparam kob_cfg_t Cfg = '{num_ch: 3, depth: 16, bank_w: 2, bank_lsb: 8};

  typedef logic [Cfg.bank_w-1:0] kob_bank_id_t;

  function automatic logic is_load(op_e op);
    return op == OpLoad;
  endfunction

  // Counter width able to represent 0..depth inclusive.
  function automatic int unsigned kob_cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/kob_fifo.sv
// One channel of the key-order buffer: circular bank-ID queue with count and sticky overflow.
module kob_fifo import mpc_types::*; #(
  parameter int unsigned Depth    = 16,
  parameter int unsigned BankW    = 2,
  parameter int unsigned AfThresh = Depth - 2,
  localparam int unsigned CntW    = kob_cnt_w(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [BankW-1:0] bank_i,
  input  logic             pop_ack_i,
  input  logic             flush_i,
  output logic             head_valid_o,
  output logic [BankW-1:0] head_bank_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic [CntW-1:0]  count_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]                 alloc_ptr_q, alloc_ptr_d;
  logic [PtrW:0]                 retire_ptr_q, retire_ptr_d;
  logic [CntW-1:0]               count_q, count_d;
  logic [Depth-1:0]              valid_q, valid_d;
  logic [Depth-1:0][BankW-1:0]   mem_q, mem_d;
  logic                          overflow_q, overflow_d;
  logic                          mem_we;

  logic [PtrW-1:0] alloc_idx, retire_idx;
  logic            ptr_full, pop, push_ok;

  assign alloc_idx  = alloc_ptr_q[PtrW-1:0];
  assign retire_idx = retire_ptr_q[PtrW-1:0];
  // Same slot, opposite lap: the writer is a full lap ahead of the reader.
  assign ptr_full   = (alloc_idx == retire_idx) && (alloc_ptr_q[PtrW] != retire_ptr_q[PtrW]);
  assign pop        = valid_q[retire_idx] & pop_ack_i;
  assign push_ok    = push_i & (~ptr_full | pop);

  always_comb begin
    alloc_ptr_d  = alloc_ptr_q;
    retire_ptr_d = retire_ptr_q;
    count_d      = count_q;
    valid_d      = valid_q;
    mem_d        = mem_q;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;
    if (flush_i) begin
      alloc_ptr_d  = '0;
      retire_ptr_d = '0;
      count_d      = '0;
      valid_d      = '0;
      overflow_d   = 1'b0;
    end else begin
      if (pop) begin
        valid_d[retire_idx] = 1'b0;
        retire_ptr_d        = retire_ptr_q + (PtrW+1)'(1);
      end
      // When full with a pop, alloc and retire share a slot; the set must win.
      if (push_ok) begin
        valid_d[alloc_idx] = 1'b1;
        mem_d[alloc_idx]   = bank_i;
        mem_we             = 1'b1;
        alloc_ptr_d        = alloc_ptr_q + (PtrW+1)'(1);
      end
      if (push_i && ptr_full && !pop) begin
        overflow_d = 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  ns_gnrl_dfflr #(.Width(PtrW+1)) u_alloc_ptr (
    .clk(clk), .rst_n(rst_n), .ld_i(1'b1), .d_i(alloc_ptr_d), .q_o(alloc_ptr_q)
  );
  ns_gnrl_dfflr #(.Width(PtrW+1)) u_retire_ptr (
    .clk(clk), .rst_n(rst_n), .ld_i(1'b1), .d_i(retire_ptr_d), .q_o(retire_ptr_q)
  );
  ns_gnrl_dfflr #(.Width(CntW)) u_count (
    .clk(clk), .rst_n(rst_n), .ld_i(1'b1), .d_i(count_d), .q_o(count_q)
  );
  ns_gnrl_dfflr #(.Width(Depth)) u_valid (
    .clk(clk), .rst_n(rst_n), .ld_i(1'b1), .d_i(valid_d), .q_o(valid_q)
  );
  ns_gnrl_dfflr #(.Width(Depth*BankW)) u_mem (
    .clk(clk), .rst_n(rst_n), .ld_i(mem_we), .d_i(mem_d), .q_o(mem_q)
  );
  ns_gnrl_dfflr #(.Width(1)) u_overflow (
    .clk(clk), .rst_n(rst_n), .ld_i(1'b1), .d_i(overflow_d), .q_o(overflow_q)
  );

  assign head_valid_o  = valid_q[retire_idx];
  assign head_bank_o   = mem_q[retire_idx];
  assign full_o        = (count_q == CntW'(Depth));
  assign almost_full_o = (count_q >= CntW'(AfThresh));
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: rtl/ns_gnrl_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset.
module ns_gnrl_dfflr #(
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= ResetVal;
    end else if (ld_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/kob_mc.sv
// Multi-channel key-order buffer: per-channel in-order bank-ID tracking for the return path.
module kob_mc import mpc_types::*; #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned BANK_LSB  = 8,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  localparam int unsigned CNT_W    = kob_cnt_w(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                u_req_valid,
  input  logic [NUM_CH-1:0]                u_req_ready,
  input  channel_req_t [NUM_CH-1:0]        u_req,
  input  logic [NUM_CH-1:0]                flush,
  output logic [NUM_CH-1:0]                d_rob_req,
  input  logic [NUM_CH-1:0]                d_rob_ack,
  output logic [NUM_CH-1:0][BANK_W-1:0]    d_rob_bank_id,
  output logic [NUM_CH-1:0]                kob_full,
  output logic [NUM_CH-1:0]                kob_almost_full,
  output logic [NUM_CH-1:0][CNT_W-1:0]     kob_count,
  output logic [NUM_CH-1:0]                kob_overflow
);

  // Only the op and bank field of each request matter here.
  logic unused_req;
  assign unused_req = ^u_req;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic              push;
    logic [BANK_W-1:0] bank;

    assign push = u_req_valid[c] & u_req_ready[c] & is_load(u_req[c].op);
    assign bank = u_req[c].addr[BANK_LSB +: BANK_W];

    kob_fifo #(
      .Depth   (DEPTH),
      .BankW   (BANK_W),
      .AfThresh(AF_THRESH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .bank_i       (bank),
      .pop_ack_i    (d_rob_ack[c]),
      .flush_i      (flush[c]),
      .head_valid_o (d_rob_req[c]),
      .head_bank_o  (d_rob_bank_id[c]),
      .full_o       (kob_full[c]),
      .almost_full_o(kob_almost_full[c]),
      .count_o      (kob_count[c]),
      .overflow_o   (kob_overflow[c])
    );
  end

endmodule
